// File: rtl/dsram_pkg.sv
// Shared constants and the byte-lane parity helper for the CPU data-SRAM responder.
package dsram_pkg;

  localparam int unsigned DSRAM_WORD_W = 32;
  localparam int unsigned DSRAM_LANES  = 4;
  localparam int unsigned DSRAM_BYTE_W = 8;

  // Even-parity bit for one byte: set when the byte holds an odd number of ones.
  function automatic logic byte_parity(input logic [DSRAM_BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/data_sram_resp_if.sv
// Execute-stage to data-SRAM port bundle; parity signals exist only with DSRAM_PARITY_EN.
interface data_sram_resp_if #(
  parameter int unsigned AW = 16
);
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
`ifdef DSRAM_PARITY_EN
  logic          data_sram_pinj;
  logic          data_sram_perr;
  logic [AW-1:0] data_sram_perr_idx;

  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, data_sram_pinj,
    input  data_sram_rdata, data_sram_perr, data_sram_perr_idx
  );
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, data_sram_pinj,
    output data_sram_rdata, data_sram_perr, data_sram_perr_idx
  );
`else
  modport master (
    output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata
  );
  modport slave (
    input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
    output data_sram_rdata
  );
`endif
endinterface

// File: rtl/dsram_lane.sv
// One byte column of the data SRAM: synchronous write, read-first registered byte output.
module dsram_lane
  import dsram_pkg::*;
#(
  parameter int unsigned AW = 16,
  parameter int unsigned W  = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [AW-1:0]           idx,
  input  logic                    rd_en,
  input  logic                    we,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            q_c,
  output logic [DSRAM_BYTE_W-1:0] dout
);

  localparam int unsigned DEPTH = 32'(1) << AW;

  logic [W-1:0] mem [DEPTH];

  // Combinational peek feeds both the output register and the parity checker.
  assign q_c = mem[idx];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
    end else if (rd_en) begin
      dout <= q_c[DSRAM_BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: byte-writable, read-first word array with 1-cycle registered read data.
// Optional per-byte parity with sticky error capture is built when DSRAM_PARITY_EN is defined.
module data_sram_resp
  import dsram_pkg::*;
#(
  parameter int unsigned AW = 16
) (
  input  logic           clk,
  input  logic           resetn,
  data_sram_resp_if.slave bus
);

`ifdef DSRAM_PARITY_EN
  localparam int unsigned LW = DSRAM_BYTE_W + 1;
`else
  localparam int unsigned LW = DSRAM_BYTE_W;
`endif

  logic [AW-1:0]           idx_c;
  logic                    acc_c;
  logic                    rd_c;
  logic [LW-1:0]           lane_din [DSRAM_LANES];
  logic [LW-1:0]           lane_q   [DSRAM_LANES];
  logic [DSRAM_BYTE_W-1:0] lane_dout[DSRAM_LANES];
  logic                    addr_unused_c;

  // Upper address bits alias and the byte offset is implied by wen.
  assign idx_c         = bus.data_sram_addr[AW+1:2];
  assign addr_unused_c = ^{bus.data_sram_addr[31:AW+2], bus.data_sram_addr[1:0]};

  // An access presented while reset is asserted is dropped.
  assign acc_c = bus.data_sram_en & resetn;
  assign rd_c  = acc_c & (bus.data_sram_wen == 4'h0);

  always_comb begin
    for (int i = 0; i < int'(DSRAM_LANES); i++) begin
      lane_din[i] = '0;
`ifdef DSRAM_PARITY_EN
      lane_din[i] = {byte_parity(bus.data_sram_wdata[8*i +: 8]) ^ bus.data_sram_pinj,
                     bus.data_sram_wdata[8*i +: 8]};
`else
      lane_din[i] = bus.data_sram_wdata[8*i +: 8];
`endif
    end
  end

  // Every access reloads the output lanes (read-first on writes); idle cycles hold rdata.
  for (genvar g = 0; g < int'(DSRAM_LANES); g++) begin : g_lane
    dsram_lane #(
      .AW (AW),
      .W  (LW)
    ) u_lane (
      .clk    (clk),
      .resetn (resetn),
      .idx    (idx_c),
      .rd_en  (acc_c),
      .we     (acc_c & bus.data_sram_wen[g]),
      .din    (lane_din[g]),
      .q_c    (lane_q[g]),
      .dout   (lane_dout[g])
    );
  end

  assign bus.data_sram_rdata = {lane_dout[3], lane_dout[2], lane_dout[1], lane_dout[0]};

`ifdef DSRAM_PARITY_EN
  logic [DSRAM_LANES-1:0] perr_lane_c;
  logic                   perr_q;
  logic [AW-1:0]          perr_idx_q;

  always_comb begin
    perr_lane_c = '0;
    for (int i = 0; i < int'(DSRAM_LANES); i++) begin
      perr_lane_c[i] = byte_parity(lane_q[i][DSRAM_BYTE_W-1:0]) != lane_q[i][DSRAM_BYTE_W];
    end
  end

  // Sticky error flag; the index of the first failing read is kept until reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perr_q     <= 1'b0;
      perr_idx_q <= '0;
    end else if (rd_c && (perr_lane_c != '0)) begin
      perr_q <= 1'b1;
      if (!perr_q) begin
        perr_idx_q <= idx_c;
      end
    end
  end

  assign bus.data_sram_perr     = perr_q;
  assign bus.data_sram_perr_idx = perr_idx_q;
`else
  logic rd_unused_c;
  assign rd_unused_c = rd_c;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: vector table plus reset and parity sequences.
module tb_data_sram_resp;

  localparam int unsigned AW = 16;

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic clk;
  logic resetn;
  int   n_tests;
  int   n_fail;

  data_sram_resp_if #(.AW(AW)) bus ();

  data_sram_resp #(.AW(AW)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic chk, input logic [31:0] exp,
                              input string name);
    vec_t v;
    v.en = en; v.wen = wen; v.addr = addr; v.wdata = wdata;
    v.chk = chk; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Drive one access at the falling edge, let the rising edge take it, sample just after.
  task automatic apply(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic pinj);
    @(negedge clk);
    bus.data_sram_en    = en;
    bus.data_sram_wen   = wen;
    bus.data_sram_addr  = addr;
    bus.data_sram_wdata = wdata;
`ifdef DSRAM_PARITY_EN
    bus.data_sram_pinj  = pinj;
`else
    if (pinj) $display("note: pinj ignored without parity");
`endif
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[18];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b1;
    bus.data_sram_en    = 1'b0;
    bus.data_sram_wen   = 4'h0;
    bus.data_sram_addr  = 32'h0;
    bus.data_sram_wdata = 32'h0;
`ifdef DSRAM_PARITY_EN
    bus.data_sram_pinj  = 1'b0;
`endif

    vecs[0]  = mk(1, 4'hF, 32'h0000_0000, 32'h1122_3344, 0, 32'h0,          "wr0");
    vecs[1]  = mk(1, 4'h0, 32'h0000_0000, 32'h0,          1, 32'h1122_3344, "rd0");
    vecs[2]  = mk(1, 4'hF, 32'h0000_0100, 32'hAABB_CCDD, 0, 32'h0,          "wr100");
    vecs[3]  = mk(1, 4'h1, 32'h0000_0100, 32'h0000_00EE, 1, 32'hAABB_CCDD, "wr100_b0_rf");
    vecs[4]  = mk(1, 4'h8, 32'h0000_0100, 32'h5500_0000, 1, 32'hAABB_CCEE, "wr100_b3_rf");
    vecs[5]  = mk(1, 4'h0, 32'h0000_0100, 32'h0,          1, 32'h55BB_CCEE, "rd100_lanes");
    vecs[6]  = mk(1, 4'hF, 32'h0000_0020, 32'h1234_5678, 0, 32'h0,          "wr20");
    vecs[7]  = mk(1, 4'hF, 32'h0000_0020, 32'h9ABC_DEF0, 1, 32'h1234_5678, "wr20_readfirst");
    vecs[8]  = mk(0, 4'hF, 32'h0000_0020, 32'h0,          1, 32'h1234_5678, "idle_hold");
    vecs[9]  = mk(1, 4'h0, 32'h0000_0020, 32'h0,          1, 32'h9ABC_DEF0, "rd20_new");
    vecs[10] = mk(1, 4'hF, 32'h0004_0010, 32'hCAFE_BABE, 0, 32'h0,          "wr_alias");
    vecs[11] = mk(1, 4'hF, 32'h0000_0014, 32'h1357_9BDF, 0, 32'h0,          "wr14");
    vecs[12] = mk(1, 4'h0, 32'h0000_0010, 32'h0,          1, 32'hCAFE_BABE, "rd10_alias");
    vecs[13] = mk(1, 4'h0, 32'h0000_0014, 32'h0,          1, 32'h1357_9BDF, "rd14_pipe");
    vecs[14] = mk(1, 4'h0, 32'h0000_0010, 32'h0,          1, 32'hCAFE_BABE, "rd10_pipe");
    vecs[15] = mk(1, 4'h0, 32'h0000_0000, 32'h0,          1, 32'h1122_3344, "rd0_intact");
    vecs[16] = mk(1, 4'h2, 32'h0000_0102, 32'h0000_7700, 1, 32'h55BB_CCEE, "wr102_b1_rf");
    vecs[17] = mk(1, 4'h0, 32'h0000_0100, 32'h0,          1, 32'h55BB_77EE, "rd100_b1");

    // Asynchronous reset assertion, observed before any rising edge.
    #2 resetn = 1'b0;
    #1;
    check("reset_async_rdata", bus.data_sram_rdata, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("reset_rel_rdata", bus.data_sram_rdata, 32'h0);
`ifdef DSRAM_PARITY_EN
    check("reset_perr", 32'(bus.data_sram_perr), 32'h0);
    check("reset_perr_idx", 32'(bus.data_sram_perr_idx), 32'h0);
`endif

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, 1'b0);
      if (vecs[i].chk) check(vecs[i].name, bus.data_sram_rdata, vecs[i].exp);
    end

`ifdef DSRAM_PARITY_EN
    check("perr_clean", 32'(bus.data_sram_perr), 32'h0);
    apply(1, 4'hF, 32'h0000_0040, 32'hFFFF_FFFF, 1'b1);
    check("perr_wr_unchecked", 32'(bus.data_sram_perr), 32'h0);
    apply(1, 4'h0, 32'h0000_0040, 32'h0, 1'b0);
    check("perr_rd40_rdata", bus.data_sram_rdata, 32'hFFFF_FFFF);
    check("perr_set", 32'(bus.data_sram_perr), 32'h1);
    check("perr_idx_first", 32'(bus.data_sram_perr_idx), 32'd16);
    apply(1, 4'h1, 32'h0000_0080, 32'h0000_0001, 1'b1);
    apply(1, 4'h0, 32'h0000_0080, 32'h0, 1'b0);
    check("perr_sticky", 32'(bus.data_sram_perr), 32'h1);
    check("perr_idx_kept", 32'(bus.data_sram_perr_idx), 32'd16);
    apply(0, 4'h0, 32'h0, 32'h0, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check("perr_reset", 32'(bus.data_sram_perr), 32'h0);
    check("perr_idx_reset", 32'(bus.data_sram_perr_idx), 32'h0);
    @(negedge clk);
    resetn = 1'b1;
`endif

    // Reset in the middle of traffic: read dropped, rdata cleared, array kept.
    apply(1, 4'hF, 32'h0000_0008, 32'h0BAD_F00D, 1'b0);
    apply(1, 4'h0, 32'h0000_0000, 32'h0, 1'b0);
    check("mid_pre_rdata", bus.data_sram_rdata, 32'h1122_3344);
    @(negedge clk);
    bus.data_sram_en   = 1'b1;
    bus.data_sram_wen  = 4'h0;
    bus.data_sram_addr = 32'h0000_0008;
    #2 resetn = 1'b0;
    #1;
    check("mid_async_rdata", bus.data_sram_rdata, 32'h0);
    @(negedge clk);
    bus.data_sram_wen   = 4'hF;
    bus.data_sram_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    check("mid_in_reset_rdata", bus.data_sram_rdata, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    bus.data_sram_en = 1'b0;
    apply(1, 4'h0, 32'h0000_0008, 32'h0, 1'b0);
    check("mid_retained", bus.data_sram_rdata, 32'h0BAD_F00D);
    apply(1, 4'h0, 32'h0000_0100, 32'h0, 1'b0);
    check("mid_retained_100", bus.data_sram_rdata, 32'h55BB_77EE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the CPU data-SRAM port. It accepts enable, byte write-enable, address and write data driven by the execute stage and returns read data one cycle later on `data_sram_rdata`, which the memory stage samples unconditionally. It holds a word-organised, byte-writable storage array with read-first semantics. It optionally adds per-byte parity with sticky error capture.

## Interface
- `AW`, 16: number of word-index bits. Depth is 2^AW words of 32 bits.
- `clk`, input, 1: single clock, rising edge.
- `resetn`, input, 1: asynchronous, active-low reset.
- `data_sram_en`, input, 1: access strobe for this cycle.
- `data_sram_wen`, input, 4: byte write enables. Bit i writes `wdata[8i+7:8i]`.
- `data_sram_addr`, input, 32: byte address.
- `data_sram_wdata`, input, 32: store data.
- `data_sram_rdata`, output, 32: registered read data.
- `data_sram_perr`, output, 1: sticky parity error. Present only with `DSRAM_PARITY_EN`.
- `data_sram_perr_idx`, output, AW: word index of the first parity error. Present only with `DSRAM_PARITY_EN`.
- `data_sram_pinj`, input, 1: parity-inject test input. When high on a write, the stored parity of every written byte is inverted. Present only with `DSRAM_PARITY_EN`.

## Operation
- Word index is `addr[AW+1:2]`.
- `addr[1:0]` is ignored; the driver supplies lane-aligned `wen` and `wdata`.
- `addr[31:AW+2]` is ignored, so addresses alias modulo 4·2^AW bytes. No error is raised for this.
- Read, when `en`=1 and `wen`=0: `rdata` is loaded with `mem[idx]` at the clock edge.
- Write, when `en`=1 and `wen`≠0:
  - Each enabled byte lane of `mem[idx]` is updated at the edge.
  - Disabled lanes are unchanged.
  - `rdata` is loaded with the pre-write word (read-first).
- Idle, when `en`=0: `rdata` holds its previous value. Memory is unchanged.
- If `wen`≠0 while `en`=0, it is ignored.
- Storage is not cleared by reset; its contents are undefined until written.
- Back-to-back accesses are supported every cycle. There is no stall or back-pressure path, consistent with the memory stage's fixed `ready_go`.

## Timing
- Reset values:
  - `data_sram_rdata` = 32'h0.
  - `data_sram_perr` = 0.
  - `data_sram_perr_idx` = 0.
- Assertion of `resetn` low clears these immediately (asynchronous). Release is synchronous to the design.
- Read latency: exactly 1 cycle. A read issued at edge N is visible after edge N and stable through cycle N+1.
- Write at edge N followed by a read of the same index at edge N+1 returns the new data at N+1.
- Write and read in the same cycle to the same index return the old data (read-first).
- Reset mid-operation:
  - An access presented in the reset cycle is dropped.
  - Array contents written before reset are retained.

## Configuration
- Macro: `DSRAM_PARITY_EN`.
- When defined:
  - Each byte lane stores an even-parity bit, computed from the written byte XOR `data_sram_pinj`.
  - On every read (`en`=1, `wen`=0), the recomputed parity of all 4 lanes is compared with the stored parity at the same edge that loads `rdata`.
  - Any mismatch sets `data_sram_perr`. If `perr` was 0, the edge also loads `perr_idx` with the word index.
  - `perr` stays set until reset. Later errors do not overwrite `perr_idx`.
  - Read-first write cycles are not checked.
  - `rdata` is delivered unmodified; there is no correction.
- When undefined:
  - No parity storage or logic is built.
  - The three parity ports are absent.

## Structure
- Shared package `dsram_pkg` holds:
  - the `DSRAM_WORD_W` (32) and `DSRAM_LANES` (4) constants;
  - the byte-lane parity function.
- One sub-module, `dsram_lane`:
  - one 8-bit (or 9-bit with parity) column of 2^AW entries;
  - a synchronous write enable and a registered, read-first output.
  - It is instantiated four times.
- The top level contains:
  - index extraction;
  - the `rdata` hold logic;
  - the parity checker and sticky error registers.

## Test plan
- Reset: hold `resetn`=0 for 3 cycles, then release → `rdata`=0 and `perr`=0 with no clock edge needed. Issue a read to addr 0x0 after writing 0x11223344 → `rdata`=0x11223344 exactly one cycle later.
- Byte lanes: write 0xAABBCCDD to 0x100 with `wen`=4'hF, then 0x000000EE with `wen`=4'h1, then 0x55000000 with `wen`=4'h8; read 0x100 → 0x55BBCCEE.
- Read-first and hold:
  - Write 0x12345678 to 0x20; next cycle, write 0x9ABCDEF0 to 0x20 → `rdata`=0x12345678.
  - Then one cycle with `en`=0 → `rdata` still 0x12345678.
  - Then read 0x20 → 0x9ABCDEF0.
- Aliasing and pipelined reads (AW=16):
  - Write 0xCAFEBABE to 0x0004_0010; read 0x0000_0010 → 0xCAFEBABE.
  - Back-to-back reads of 0x10, 0x14, 0x10 each return the correct word on consecutive cycles.
- Parity (`DSRAM_PARITY_EN`):
  - Write 0xFFFFFFFF to 0x40 with `pinj`=1; read 0x40 → `rdata`=0xFFFFFFFF, `perr`=1 and `perr_idx`=16 on the following cycle.
  - A second injected error at 0x80 leaves `perr_idx`=16.
  - `resetn` pulse clears both.
- Reset mid-operation: write 0x0BADF00D to 0x8; assert reset during a read of 0x8 → `rdata` drops to 0 asynchronously. After release, read 0x8 → 0x0BADF00D.
